// File: rtl/uart_pkg.sv
// Shared UART types: parity selection and receiver state encoding.
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_cfg_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to idle-high.
module uart_sync (
    input  logic clk_in,
    input  logic rst_in,
    input  logic d_in,
    output logic q_out
);

    logic r_meta;
    logic r_sync;

    // Double-register the line; reset to 1 so a reset never looks like a start bit.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= d_in;
            r_sync <= r_meta;
        end
    end

    assign q_out = r_sync;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: mid-bit sampling, optional parity, 1/2 stop bits,
// held output word with parity/frame/overrun flags and break handling.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int      CLOCKS_PER_BAUD = 33,
    parameter int      DATA_BITS       = 8,
    parameter parity_t PARITY          = PARITY_NONE,
    parameter int      STOP_BITS       = 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 uart_rxd_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 parity_err_out,
    output logic                 frame_err_out,
    output logic                 overrun_out,
    output logic                 busy_out
);

    localparam int            CW        = $clog2(CLOCKS_PER_BAUD);
    localparam logic [CW-1:0] CNT_FULL  = CW'(CLOCKS_PER_BAUD - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    logic                 w_rxd_s;
    logic                 w_cnt_zero;
    logic                 w_par_calc;
    logic                 w_par_exp;
    logic                 w_ferr_now;

    rx_state_t            r_state;
    logic [CW-1:0]        r_cnt;
    logic [2:0]           r_bit_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic                 r_frm_err;
    logic                 r_armed;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_ovr;

    uart_sync u_sync (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d_in   (uart_rxd_in),
        .q_out  (w_rxd_s)
    );

    assign w_cnt_zero = (r_cnt == '0);
    assign w_par_calc = ^r_shift;
    assign w_par_exp  = (PARITY == PARITY_ODD) ? ~w_par_calc : w_par_calc;
    // Frame error accumulates across stop bits including the current sample.
    assign w_ferr_now = r_frm_err | ~w_rxd_s;

    // Receive FSM, baud counter, shifter and held output word.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_armed    <= 1'b1;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            // Consumer handshake; a word loading this cycle overrides below.
            if (r_valid && ready_in)
                r_valid <= 1'b0;

            if (r_state != ST_IDLE && !w_cnt_zero)
                r_cnt <= r_cnt - 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (!r_armed) begin
                        // Stay deaf after a break until the line goes idle again.
                        if (w_rxd_s)
                            r_armed <= 1'b1;
                    end else if (!w_rxd_s) begin
                        r_state <= ST_START;
                        r_cnt   <= CNT_HALF;
                    end
                end

                ST_START: begin
                    if (w_cnt_zero) begin
                        if (w_rxd_s) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state   <= ST_DATA;
                            r_cnt     <= CNT_FULL;
                            r_bit_idx <= '0;
                            r_par_err <= 1'b0;
                            r_frm_err <= 1'b0;
                        end
                    end
                end

                ST_DATA: begin
                    if (w_cnt_zero) begin
                        r_shift <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
                        r_cnt   <= CNT_FULL;
                        if (r_bit_idx == BIT_LAST) begin
                            r_state    <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                            r_stop_idx <= 1'b0;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (w_cnt_zero) begin
                        r_par_err <= (w_rxd_s != w_par_exp);
                        r_cnt     <= CNT_FULL;
                        r_state   <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (w_cnt_zero) begin
                        if (r_stop_idx == STOP_LAST) begin
                            r_state <= ST_IDLE;
                            r_data  <= r_shift;
                            r_perr  <= r_par_err;
                            r_ferr  <= w_ferr_now;
                            r_ovr   <= r_valid & ~ready_in;
                            r_valid <= 1'b1;
                            r_armed <= ~w_ferr_now;
                        end else begin
                            r_frm_err  <= w_ferr_now;
                            r_stop_idx <= 1'b1;
                            r_cnt      <= CNT_FULL;
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign data_out       = r_data;
    assign valid_out      = r_valid;
    assign parity_err_out = r_perr;
    assign frame_err_out  = r_ferr;
    assign overrun_out    = r_ovr;
    assign busy_out       = (r_state != ST_IDLE);

endmodule
